// File: rtl/mdu_pkg.sv
// Shared types, opcode constants and operand-sign helpers for the M-extension sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Divide/remainder group occupies the upper half of the encoding
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Accumulator layout is {hi, lo}: multiply keeps {partial product, multiplier},
// divide keeps {partial remainder, dividend/quotient}. Both modes share one XLEN+1 adder.
module mdu_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  localparam int unsigned SW = XLEN + 1;

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [SW-1:0]   add_a;
  logic [SW-1:0]   add_b;
  logic [SW-1:0]   sum;

  assign hi = acc_i[2*XLEN-1:XLEN];
  assign lo = acc_i[XLEN-1:0];

  // Shared adder; divide subtracts via inverted operand plus carry-in
  always_comb begin
    add_a = '0;
    add_b = '0;
    sum   = '0;
    acc_o = acc_i;
    if (is_div_i) begin
      add_a = {hi, lo[XLEN-1]};
      add_b = ~{1'b0, opnd_i};
    end else begin
      add_a = {1'b0, hi};
      add_b = lo[0] ? {1'b0, opnd_i} : '0;
    end
    sum = add_a + add_b + SW'(is_div_i);
    if (is_div_i) begin
      // sum[XLEN] set means the trial subtraction went negative: restore
      acc_o = sum[XLEN] ? {acc_i[2*XLEN-2:0], 1'b0}
                        : {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {sum, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RISC-V M-extension unit: fixed XLEN+2 cycle latency for every operation.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned DW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN) + 1;

  mdu_state_t      state_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] opnd_q;
  logic [DW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            rneg_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [DW-1:0]   acc_step;
  logic [DW-1:0]   prod_s;
  logic [XLEN-1:0] quot_s;
  logic [XLEN-1:0] rem_s;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] fix_res;

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

  // Operand magnitudes and signs for the latched operation
  always_comb begin
    a_neg = a_q[XLEN-1] & f3_signed_a(f3_q);
    b_neg = b_q[XLEN-1] & f3_signed_b(f3_q);
    a_abs = a_neg ? -a_q : a_q;
    b_abs = b_neg ? -b_q : b_q;
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div_i (f3_is_div(f3_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  // Sign correction, half/quotient/remainder selection and special cases
  always_comb begin
    prod_s   = neg_q  ? -acc_q : acc_q;
    quot_s   = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s    = rneg_q ? -acc_q[DW-1:XLEN] : acc_q[DW-1:XLEN];
    div_zero = (b_q == '0);
    div_ovf  = (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
    fix_res  = '0;
    case (f3_q)
      F3_MUL:                       fix_res = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_s[DW-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (div_zero)                     fix_res = '1;
        else if (f3_q == F3_DIV && div_ovf) fix_res = a_q;
        else                              fix_res = quot_s;
      end
      default: begin
        if (div_zero)                     fix_res = a_q;
        else if (f3_q == F3_REM && div_ovf) fix_res = '0;
        else                              fix_res = rem_s;
      end
    endcase
  end

  // Control FSM and datapath registers; abort wins over start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (abort) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            f3_q    <= Funct3;
            a_q     <= SrcA;
            b_q     <= SrcB;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          if (f3_is_div(f3_q)) begin
            opnd_q <= b_abs;
            acc_q  <= {{XLEN{1'b0}}, a_abs};
          end else begin
            opnd_q <= a_abs;
            acc_q  <= {{XLEN{1'b0}}, b_abs};
          end
          neg_q   <= a_neg ^ b_neg;
          rneg_q  <= a_neg;
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            f3_q    <= Funct3;
            a_q     <= SrcA;
            b_q     <= SrcB;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed vectors with hand-computed results.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned LAT  = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    int unsigned     e0;
    int              id;
  } exp_t;

  exp_t            sb_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              op_id    = 0;
  logic [XLEN-1:0] last_res = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("result_op%0d", e.id), Result, e.res);
        check($sformatf("latency_op%0d", e.id), 32'(cyc - e.e0), 32'(LAT));
        check($sformatf("busy_at_done_op%0d", e.id), 32'(busy), 32'd0);
      end
    end
  end

  // Drive start for one cycle from a negedge; optionally register an expected result
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input bit expect_done, input logic [XLEN-1:0] exp);
    exp_t e;
    start  = 1'b1;
    Funct3 = f;
    SrcA   = a;
    SrcB   = b;
    if (expect_done) begin
      e.res = exp;
      e.e0  = cyc + 1;
      e.id  = op_id;
      sb_q.push_back(e);
    end
    op_id++;
    @(negedge clk);
    start  = 1'b0;
    Funct3 = 3'($urandom);
    SrcA   = $urandom;
    SrcB   = $urandom;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp);
    issue(f, a, b, 1'b1, exp);
    wait_done();
    last_res = exp;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    Funct3 = '0;
    SrcA   = '0;
    SrcB   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", Result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply group; MULHU issued back-to-back in the DONE cycle of MUL
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
    wait_done();
    issue(F3_MULHU, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'h0000_0006);
    wait_done();
    last_res = 32'h0000_0006;
    @(negedge clk);
    run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(F3_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F);

    // Divide group including divide-by-zero and signed overflow
    run_op(F3_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op(F3_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op(F3_DIVU, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
    run_op(F3_DIVU, 32'd123,       32'd0,         32'hFFFF_FFFF);
    run_op(F3_REMU, 32'd123,       32'd0,         32'd123);
    run_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op(F3_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_op(F3_REM,  32'd100,       32'hFFFF_FFF9, 32'd2);

    // Abort near cycle 10: no done, Result held
    issue(F3_DIV, 32'd1000, 32'd7, 1'b0, '0);
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result_held", Result, last_res);
    repeat (40) @(negedge clk);
    check("abort_result_still_held", Result, last_res);

    // Start while busy is ignored
    issue(F3_MUL, 32'd5, 32'd6, 1'b1, 32'd30);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    Funct3 = F3_DIVU;
    SrcA   = 32'd99;
    SrcB   = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    last_res = 32'd30;
    @(negedge clk);
    repeat (40) @(negedge clk);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Synchronous reset in the middle of a DIV
    issue(F3_DIV, 32'd1000, 32'd3, 1'b1, 32'd333);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", Result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multi-cycle sequencer for the RISC-V M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the main ALU in the execute stage. It accepts operands and Funct3 from the decode/controller path when the controller signals an M-type R-instruction (Funct7 = 0000001). It runs a fixed-latency radix-2 shift-add / restoring shift-subtract loop and stalls the pipeline until the result is written back.

## Interface
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when the FSM is in IDLE or DONE.
- abort  in  1  pipeline flush; cancels any in-flight operation.
- Funct3  in  3  operation select, sampled with start.
- SrcA  in  XLEN  rs1 operand (multiplicand/dividend), sampled with start.
- SrcB  in  XLEN  rs2 operand (multiplier/divisor), sampled with start.
- busy  out  1  high in PREP, CALC, FIX; drives the pipeline stall.
- done  out  1  one-cycle pulse when Result is valid.
- Result  out  XLEN  registered result; held until the next done.

## Operation
- Funct3 encoding:
  - 000 MUL: low XLEN bits.
  - 001 MULH: signed×signed, high bits.
  - 010 MULHSU: signed×unsigned, high bits.
  - 011 MULHU: unsigned×unsigned, high bits.
  - 100 DIV and 101 DIVU: quotient.
  - 110 REM and 111 REMU: remainder.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
  - IDLE: start=1 latches Funct3/SrcA/SrcB and goes to PREP.
  - PREP: takes absolute values of signed operands, records result sign, clears the accumulator, sets count=0, goes to CALC.
  - CALC: one shift-add (multiply) or shift-subtract-restore (divide) step per cycle. After step XLEN-1, goes to FIX.
  - FIX: applies sign correction and selects the low/high half or quotient/remainder. Loads Result and goes to DONE.
  - DONE: done=1. If start=1, latch the new operands and go to PREP (back-to-back issue); otherwise go to IDLE.
- Sign rules:
  - Product negated when the operand signs differ (signed operands only).
  - Quotient negated when the signs differ.
  - Remainder takes the dividend's sign.
- Special cases are resolved in FIX with no shortened latency:
  - Divide by zero: quotient = all ones; remainder = SrcA.
  - Signed overflow (SrcA = 1<<(XLEN-1), SrcB = all ones): quotient = SrcA; remainder = 0.
- Internal widths:
  - 2·XLEN product/remainder:quotient register.
  - XLEN+1 bit subtractor.
  - Counter $clog2(XLEN)+1 bits.
- start while busy=1 is ignored; no queuing.
- abort=1 in any state returns the FSM to IDLE on the next edge. No done is issued and Result is unchanged. abort has priority over start in the same cycle.
- start with a Funct3 latched and Funct7 ignored: the caller gates start with the M-type decode.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, Result=0, counter=0, internal registers=0.
- Reset mid-operation: same as above; the operation is discarded.
- Latency: start sampled at edge E0 gives done high during the cycle after edge E(XLEN+2). That is 34 cycles for XLEN=32, identical for every Funct3 and operand value.
- busy rises the cycle after E0 and falls in the same cycle done rises.
- Result changes only on the edge that enters DONE.
- Throughput: one operation per XLEN+2 cycles with back-to-back start in DONE.
- Inputs are required stable only in the start cycle.

## Structure
- Package mdu_pkg:
  - typedef enum logic [2:0] mdu_state_t {IDLE, PREP, CALC, FIX, DONE}.
  - localparam Funct3 constants F3_MUL … F3_REMU.
  - localparam FUNCT7_MULDIV = 7'b0000001.
- One sub-module, mdu_step: combinational single iteration. Inputs are mode (mul/div), accumulator, and operand; output is the next accumulator. It is reused every CALC cycle. All registers and the FSM live in mdu_sequencer.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3): done exactly 34 cycles after start; Result=0xFFFFFFEB. MULHU same operands: Result=0x00000006.
- MULH 0x80000000 × 0x80000000 gives Result=0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives Result=0xFFFFFFFF.
- DIV −7/2 gives 0xFFFFFFFD. REM −7/2 gives 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 gives 0x7FFFFFFC.
- DIVU 123/0 gives 0xFFFFFFFF and REMU 123/0 gives 123. DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0. Latency stays 34.
- Control checks:
  - abort at cycle 10 of an op: busy=0 the next cycle, no done, Result unchanged.
  - start asserted while busy: ignored.
  - start in the DONE cycle: second done 34 cycles later.
- rst_n=0 at cycle 20 of a DIV: next cycle busy=0, done=0, Result=0. A fresh op after reset completes correctly.
